// File: rtl/calc_pkg.sv
// Shared definitions for the calculation path: operation codes, the
// sequential ALU state encoding and the datapath width used by the
// controller and the ALU.
package calc_pkg;

  localparam int CALC_WIDTH = 16;

  // Opcode as presented by the controller on the op port.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_t;

  // Sequencer states of the ALU.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Function selected in the shared iterative datapath.
  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared magnitude datapath: LSB-first shift-add multiply and restoring
// divide, one bit per step. Both functions reuse the same hi/lo register
// pair and the same WIDTH+1 bit adder.
//
// MUL: lo holds the multiplier, m the multiplicand; {hi, lo} ends up as the
//      2*WIDTH-bit product.
// DIV: lo holds the dividend and collects quotient bits, m the divisor,
//      hi the partial remainder; result is {remainder, quotient}.
//
// result is the value the register pair takes at the current step, and
// done flags that the current step is the last one, so the caller can
// capture the final answer on the same edge that retires the last step.
module seq_alu_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  iter_mode_t         mode,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  iter_mode_t       mode_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

  // One multiply or divide step computed from the current register pair.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    hi_nx   = hi;
    lo_nx   = lo;
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    if (mode_q == MODE_MUL) begin
      // Add the multiplicand if the current multiplier bit is set, then
      // shift the whole pair right by one.
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      // Trial subtraction fits: keep it and shift in a 1 quotient bit.
      hi_nx = diff[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      // Trial subtraction went negative: restore and shift in a 0.
      hi_nx = shifted[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
  end

  assign result = {hi_nx, lo_nx};
  assign done   = (cnt == CW'(WIDTH - 1));

  // Operand load and per-step register update.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the working registers are cleared on reset as well, so an
    // aborted calculation leaves no stale partial state behind.
    if (reset) begin
      mode_q <= MODE_MUL;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      cnt    <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      mode_q <= mode;
      hi     <= '0;
      lo     <= (mode == MODE_MUL) ? opb : opa;
      m      <= (mode == MODE_MUL) ? opa : opb;
      cnt    <= '0;
    end else if (step) begin
      hi     <= hi_nx;
      lo     <= lo_nx;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU for the controller's start_calc/ALU_finish
// handshake. ADD/SUB and divide-by-zero resolve after one CALC cycle;
// MUL/DIV run WIDTH steps through seq_alu_iter on operand magnitudes and
// get their sign restored here. ALU_out and the flags are registered and
// change only on entry to DONE; ALU_finish marks the DONE cycle.
module seq_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_calc,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ALU_in1,
  input  logic [WIDTH-1:0] ALU_in2,
  output logic [WIDTH-1:0] ALU_out,
  output logic             ALU_finish,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero
);

  // Product magnitude limits for the positive and negative result ranges.
  localparam logic [2*WIDTH-1:0] MAG_POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAG_NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  alu_state_t       state;
  alu_state_t       next_state;
  alu_op_t          op_in;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             neg_q;
  logic             quick;

  logic             load;
  logic             step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             iter_done;
  logic [2*WIDTH-1:0] iter_result;
  iter_mode_t       iter_mode;

  logic [WIDTH-1:0]   res_out;
  logic               res_ovf;
  logic               res_dbz;
  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   quot_fix;

  assign op_in = alu_op_t'(op);

  // Magnitudes of the incoming operands; |-2^(WIDTH-1)| still fits unsigned.
  assign a_mag     = ALU_in1[WIDTH-1] ? (~ALU_in1 + 1'b1) : ALU_in1;
  assign b_mag     = ALU_in2[WIDTH-1] ? (~ALU_in2 + 1'b1) : ALU_in2;
  assign iter_mode = (op_in == OP_DIV) ? MODE_DIV : MODE_MUL;

  // Operations that finish after a single CALC cycle.
  assign neg_q = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign quick = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                 ((op_q == OP_DIV) && (b_q == '0));

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .mode   (iter_mode),
    .opa    (a_mag),
    .opb    (b_mag),
    .done   (iter_done),
    .result (iter_result)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and datapath control; start_calc is only looked at in IDLE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start_calc) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        if (quick) begin
          next_state = DONE;
        end else begin
          step = 1'b1;
          if (iter_done) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, captured together with the opcode on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load) begin
      op_q <= op_in;
      a_q  <= ALU_in1;
      b_q  <= ALU_in2;
    end
  end

  // Result value, sign fix-up and flags for the operation in progress.
  always_comb begin
    res_out  = '0;
    res_ovf  = 1'b0;
    res_dbz  = 1'b0;
    add_res  = a_q + b_q;
    sub_res  = a_q - b_q;
    prod_fix = neg_q ? (~iter_result + 1'b1) : iter_result;
    quot     = iter_result[WIDTH-1:0];
    quot_fix = neg_q ? (~quot + 1'b1) : quot;
    case (op_q)
      OP_ADD: begin
        res_out = add_res;
        res_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_out = sub_res;
        res_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res_out = prod_fix[WIDTH-1:0];
        res_ovf = neg_q ? (iter_result > MAG_NEG_MAX) : (iter_result > MAG_POS_MAX);
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_dbz = 1'b1;
        end else begin
          // Only -2^(WIDTH-1) / -1 yields a positive quotient of 2^(WIDTH-1).
          res_out = quot_fix;
          res_ovf = !neg_q && quot[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

  // Output registers, loaded only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALU_out     <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if ((state == CALC) && (next_state == DONE)) begin
      ALU_out     <= res_out;
      overflow    <= res_ovf;
      div_by_zero <= res_dbz;
    end
  end

  assign ALU_finish = (state == DONE);
  assign busy       = (state != IDLE);

endmodule
